// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_addsub_full_adder_bit.sv
// Single combinational full-adder cell shared by every bit position.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract: one bit per clock, LSB first,
// through one full-adder cell and a carry flip-flop.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nxt;

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (s_bit),
    .cout (c_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
          if (start) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub}};
            c     <= sub;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr <= {s_bit, r_sr[WIDTH-1:1]};
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          // On the MSB bit, c is the carry into the MSB and c_nxt the carry out.
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= {s_bit, r_sr[WIDTH-1:1]};
            cout     <= c_nxt;
            overflow <= c ^ c_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: expectations queued at start, checked on done.
module tb_serial_addsub;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] full;
    exp_t       e;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   full = {1'b0, x} + {1'b0, y};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (s) e.ovf = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
    else   e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("sum", 32'(sum), 32'(mon_e.sum));
        chk("cout", 32'(cout), 32'(mon_e.cout));
        chk("overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input exp_t e);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    q.push_back(e);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_dir(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input exp_t e);
    int n;
    start_op(x, y, s, e);
    wait_done(n);
    chk({tag, "_latency"}, 32'(n), 32'(W + 1));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations
    do_dir("add_5_3",  4'b0101, 4'b0011, 1'b0, {4'b1000, 1'b1 ^ 1'b1, 1'b1});
    do_dir("sub_5_3",  4'b0101, 4'b0011, 1'b1, {4'b0010, 1'b1, 1'b0});
    do_dir("sub_3_5",  4'b0011, 4'b0101, 1'b1, {4'b1110, 1'b0, 1'b0});
    do_dir("add_f_1",  4'b1111, 4'b0001, 1'b0, {4'b0000, 1'b1, 1'b0});
    do_dir("sub_8_1",  4'b1000, 4'b0001, 1'b1, {4'b0111, 1'b1, 1'b1});

    // Back-to-back: second start lands in the DONE cycle
    start_op(4'b0010, 4'b0011, 1'b0, {4'b0101, 1'b0, 1'b0});
    wait_done(n);
    start_op(4'b0111, 4'b0001, 1'b0, {4'b1000, 1'b0, 1'b1});
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'(W + 1));
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 32'd0);

    // start during RUN must be ignored
    nd = n_done;
    start_op(4'b0110, 4'b0001, 1'b0, {4'b0111, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd1);
    a = 4'b1111;
    b = 4'b1111;
    sub = 1'b1;
    start = 1'b1;
    wait_done(n);
    chk("ign_latency", 32'(n), 32'(W - 1));
    repeat (8) @(negedge clk);
    chk("ign_one_done", 32'(n_done - nd), 32'd1);
    chk("ign_queue", 32'(q.size()), 32'd0);

    // Reset in the second RUN cycle discards the operation
    nd = n_done;
    start_op(4'b0101, 4'b0011, 1'b0, {4'b1000, 1'b0, 1'b1});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    void'(q.pop_back());
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", 32'(n_done - nd), 32'd0);
    do_dir("post_rst", 4'b0100, 4'b0110, 1'b1, {4'b1110, 1'b0, 1'b0});

    // Exhaustive sweep against the reference model, issued back-to-back
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < (1 << W); x++) begin
        for (int y = 0; y < (1 << W); y++) begin
          start_op(W'(x), W'(y), 1'(s), model(W'(x), W'(y), 1'(s)));
          wait_done(n);
          chk("sweep_latency", 32'(n), 32'(W + 1));
        end
      end
    end
    @(negedge clk);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial two's-complement adder/subtractor. It processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It trades the area of a parallel ripple-carry add/subtract unit for WIDTH cycles of latency and presents the same result set: sum, carry-out and signed overflow. It sits beside the combinational arithmetic blocks as the low-area alternative for datapaths that tolerate multi-cycle operations.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block is not busy
- sub  in  1  0 = A+B, 1 = A−B; captured with start
- a  in  WIDTH  operand A; captured with start
- b  in  WIDTH  operand B; captured with start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when results update
- sum  out  WIDTH  result, held until the next completion
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow, A ≥ B unsigned)
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - start=1 loads a into the A shift register, b XOR {WIDTH{sub}} into the B shift register, sub into the carry FF, and clears the bit counter.
  - Then → RUN.
- **RUN**, each cycle:
  - s = A[0]^B[0]^c and c' = majority(A[0],B[0],c).
  - A and B shift right; s shifts into the MSB of the result shift register.
  - The counter increments.
  - On the bit WIDTH−1 edge, c (the carry into the MSB) is saved for overflow.
  - When the counter reaches WIDTH−1 and that bit is processed → DONE.
- **Entering DONE:** sum, cout and overflow are registered from the shift register and the carry FF.
- **DONE:** done=1 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back), → RUN.
  - Otherwise → IDLE.
- start while in RUN is ignored: no queuing, and operands are unaffected.
- sum, cout and overflow change only on entry to DONE. Intermediate bits are never visible on sum.
- All arithmetic is modulo 2^WIDTH. The a and b inputs may change freely after the capture edge.

## Timing
- Start accepted at edge k:
  - busy=1 for cycles k+1 … k+WIDTH.
  - Results and done valid in cycle k+WIDTH+1.
  - Latency is WIDTH+1 cycles from start to done.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- busy=0 in IDLE and DONE. done=0 except in DONE.
- rst=1 at any edge, including mid-RUN:
  - state=IDLE and counter=0.
  - Shift registers, carry FF, sum, cout, overflow, busy and done all become 0.
  - The in-flight operation is discarded and done is never raised for it.
- rst has priority over start in the same cycle.

## Structure
- Package serial_addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE) with a 2-bit encoding;
  - the counter-width localparam $clog2(WIDTH).
- One sub-module, full_adder_bit (a, b, cin → s, cout), purely combinational.
  - Instantiated once; the carry FF and shift registers live in the top module.

## Test plan
- Add, WIDTH=4: a=0101, b=0011, sub=0 → after 5 cycles sum=1000, cout=0, overflow=1; done high for exactly one cycle.
- Subtract: a=0101, b=0011, sub=1 → sum=0010, cout=1, overflow=0. Then a=0011, b=0101 → sum=1110, cout=0, overflow=0.
- Edge values:
  - a=1111, b=0001, add → sum=0000, cout=1, overflow=0.
  - a=1000, b=0001, sub → sum=0111, cout=1, overflow=1.
- Busy ignore and back-to-back:
  - Pulse start again during RUN with different operands → the first result is unaffected and no extra done pulse appears.
  - start asserted in the DONE cycle → the second result's done arrives 5 cycles later.
- Reset mid-operation: assert rst at the 2nd RUN cycle → next cycle all outputs 0 and state IDLE; no done pulse; a fresh start then completes correctly.
- Exhaustive sweep: all 256 (a,b) pairs × sub ∈ {0,1} against a reference model of sum, cout and overflow.
